// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO, status and control registers
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_op,
  input  logic [3:0]  dmem_mask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        hit,
  output logic        uart_tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t         r_state, w_nstate;
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wp, r_rp;
  logic [CW-1:0]  r_cnt;
  logic           r_en, r_ovf, r_tx;
  logic [TW-1:0]  r_timer, w_timer;
  logic [2:0]     r_bit, w_bit;
  logic [7:0]     r_shift, w_shift;
  logic           w_wr, w_full, w_empty, w_push, w_pop, w_last, w_busy, w_tx;
  logic           w_unused;
  assign hit      = dmem_addr[31:4] == BASE_ADDR[31:4];
  assign w_wr     = hit && dmem_op && dmem_mask[0];
  assign w_full   = r_cnt == CW'(FIFO_DEPTH);
  assign w_empty  = r_cnt == '0;
  assign w_push   = w_wr && dmem_addr[3:2] == 2'd0 && !w_full;
  assign w_last   = r_timer == TW'(CLKS_PER_BIT - 1);
  assign w_busy   = r_state != IDLE;
  assign w_pop    = r_en && !w_empty && (r_state == IDLE || (r_state == STOP && w_last));
  assign uart_tx  = r_tx;
  assign w_unused = ^{dmem_addr[1:0], dmem_mask[3:1], dmem_wdata[31:8]};
  assign dmem_rdata = !hit                   ? '0 :
                      dmem_addr[3:2] == 2'd1 ? {19'd0, 5'(r_cnt), 4'd0, r_ovf, w_empty, w_full, w_busy} :
                      dmem_addr[3:2] == 2'd2 ? {31'd0, r_en} : '0;
  always_comb begin
    w_nstate = r_state;
    w_timer  = (r_state == IDLE || w_last) ? '0 : r_timer + TW'(1);
    w_bit    = r_bit;
    w_shift  = r_shift;
    if (w_pop) begin
      w_nstate = START;
      w_shift  = r_mem[r_rp];
    end else if (w_last) begin
      case (r_state)
        START: w_nstate = DATA;
        DATA: begin
          w_shift  = r_shift >> 1;
          w_bit    = r_bit + 3'd1;
          w_nstate = r_bit == 3'd7 ? STOP : DATA;
        end
        STOP:    w_nstate = IDLE;
        default: w_nstate = r_state;
      endcase
    end
    // line level is registered from the next state so it changes on the same edge as the FSM
    w_tx = w_nstate == START ? 1'b0 : w_nstate == DATA ? w_shift[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_nstate;
      r_timer <= w_timer;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_tx    <= w_tx;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_en  <= 1'b1;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (w_wr && dmem_addr[3:2] == 2'd2) begin
        r_en <= dmem_wdata[0];
        if (dmem_wdata[1]) r_ovf <= 1'b0;
      end else if (w_wr && dmem_addr[3:2] == 2'd0 && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= dmem_wdata[7:0];
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed bench for uart_tx_mmio at 4 clocks per bit with a 4-entry FIFO
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'h1000_0000;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dmem_addr;
  logic        dmem_op;
  logic [3:0]  dmem_mask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        hit;
  logic        uart_tx;
  int          n_chk = 0;
  int          n_fail = 0;
  uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_op(dmem_op), .dmem_mask(dmem_mask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .hit(hit), .uart_tx(uart_tx)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] mask);
    dmem_addr  = BASE + off;
    dmem_op    = 1'b1;
    dmem_mask  = mask;
    dmem_wdata = data;
    @(negedge clk);
    dmem_op   = 1'b0;
    dmem_mask = 4'd0;
    dmem_addr = BASE + 32'h4;
  endtask
  task automatic chk_reg(input string tag, input logic [31:0] off, input logic [31:0] exp);
    dmem_addr = BASE + off;
    dmem_op   = 1'b0;
    #1;
    check(tag, dmem_rdata, exp);
  endtask
  task automatic expect_frame(input string tag, input logic [7:0] b, input int first);
    int k;
    logic e;
    for (int i = first; i < 40; i++) begin
      k = i / 4;
      e = k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
      check(tag, {31'd0, uart_tx}, {31'd0, e});
      @(negedge clk);
    end
  endtask
  initial begin
    rst = 1'b0; dmem_op = 1'b0; dmem_mask = 4'd0; dmem_wdata = '0; dmem_addr = BASE + 32'h4;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk_reg("rst_status", 32'h4, 32'h004);
    chk_reg("rst_ctrl", 32'h8, 32'h1);
    chk_reg("txdata_reads0", 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    wr(32'h0, 32'hA5, 4'hF);
    chk_reg("a5_queued", 32'h4, 32'h100);
    @(negedge clk);
    chk_reg("a5_busy", 32'h4, 32'h005);
    expect_frame("a5_frame", 8'hA5, 0);
    chk_reg("a5_done", 32'h4, 32'h004);
    wr(32'h0, 32'h01, 4'hF);
    wr(32'h0, 32'h02, 4'hF);
    expect_frame("b2b_01", 8'h01, 0);
    expect_frame("b2b_02", 8'h02, 0);
    chk_reg("b2b_done", 32'h4, 32'h004);
    wr(32'h8, 32'h0, 4'hF);
    wr(32'h0, 32'h11, 4'hF);
    wr(32'h0, 32'h22, 4'hF);
    wr(32'h0, 32'h33, 4'hF);
    wr(32'h0, 32'h44, 4'hF);
    wr(32'h0, 32'h55, 4'hF);
    wr(32'h0, 32'h66, 4'hF);
    chk_reg("ovf_status", 32'h4, 32'h40A);
    chk_reg("ovf_ctrl", 32'h8, 32'h0);
    wr(32'h8, 32'h3, 4'hF);
    chk_reg("ovf_cleared", 32'h4, 32'h402);
    chk_reg("ctrl_w1c_reads0", 32'h8, 32'h1);
    @(negedge clk);
    expect_frame("fifo_11", 8'h11, 0);
    expect_frame("fifo_22", 8'h22, 0);
    expect_frame("fifo_33", 8'h33, 0);
    expect_frame("fifo_44", 8'h44, 0);
    chk_reg("fifo_done", 32'h4, 32'h004);
    dmem_addr = BASE + 32'h14;
    #1;
    check("miss_hit", {31'd0, hit}, 32'd0);
    check("miss_rdata", dmem_rdata, 32'd0);
    dmem_addr = BASE + 32'h4;
    #1;
    check("hit_status", {31'd0, hit}, 32'd1);
    wr(32'h0, 32'h77, 4'b1110);
    chk_reg("mask_nopush", 32'h4, 32'h004);
    @(negedge clk);
    check("mask_tx_idle", {31'd0, uart_tx}, 32'd1);
    wr(32'hC, 32'hFFFF_FFFF, 4'hF);
    chk_reg("reg_c_reads0", 32'hC, 32'h0);
    chk_reg("reg_c_ctrl", 32'h8, 32'h1);
    wr(32'h10, 32'h99, 4'hF);
    chk_reg("miss_nopush", 32'h4, 32'h004);
    wr(32'h8, 32'h0, 4'b1110);
    chk_reg("ctrl_mask", 32'h8, 32'h1);
    wr(32'h0, 32'hA5, 4'hF);
    repeat (18) @(negedge clk);
    check("pre_rst_bit3", {31'd0, uart_tx}, 32'd0);
    chk_reg("pre_rst_status", 32'h4, 32'h005);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
    chk_reg("mid_rst_status", 32'h4, 32'h004);
    chk_reg("mid_rst_ctrl", 32'h8, 32'h1);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_idle", {31'd0, uart_tx}, 32'd1);
    end
    chk_reg("post_rst_status", 32'h4, 32'h004);
    wr(32'h0, 32'h5A, 4'hF);
    wr(32'h0, 32'hC3, 4'hF);
    wr(32'h8, 32'h0, 4'hF);
    expect_frame("dis_5a", 8'h5A, 1);
    chk_reg("dis_idle", 32'h4, 32'h100);
    for (int i = 0; i < 8; i++) begin
      check("dis_hold", {31'd0, uart_tx}, 32'd1);
      @(negedge clk);
    end
    chk_reg("dis_still", 32'h4, 32'h100);
    chk_reg("dis_ctrl", 32'h8, 32'h0);
    wr(32'h8, 32'h1, 4'hF);
    @(negedge clk);
    expect_frame("reen_c3", 8'hC3, 0);
    chk_reg("reen_done", 32'h4, 32'h004);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
